// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and the ALU control decoder:
// FSM state codes, primary opcodes and ALUOp classes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StIExec    = 4'd8,
    StIWb      = 4'd9,
    StBranch   = 4'd10,
    StJump     = 4'd11,
    StIllegal  = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluR   = 3'b111;
  localparam logic [2:0] AluAdd = 3'b100;
  localparam logic [2:0] AluOr  = 3'b101;
  localparam logic [2:0] AluAnd = 3'b110;
  localparam logic [2:0] AluLui = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;

  // ALU class for the immediate-format instructions; anything else falls back to ADD.
  function automatic logic [2:0] imm_alu_op(logic [5:0] op);
    logic [2:0] aop;
    case (op)
      OpAndi:  aop = AluAnd;
      OpOri:   aop = AluOr;
      OpLui:   aop = AluLui;
      default: aop = AluAdd;
    endcase
    return aop;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM (Moore). Optional memory wait states in FETCH,
// MEM_READ and MEM_WRITE are enabled with the MEM_WAIT_EN macro.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       BranchEQ,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);
  import mips_ctrl_pkg::*;

  state_e r_state;
  state_e w_next;
  logic   w_mem_ok;

`ifdef MEM_WAIT_EN
  assign w_mem_ok = MemReady;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = MemReady;
  assign w_mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StFetch:    w_next = w_mem_ok ? StDecode : StFetch;
      StDecode: begin
        case (Opcode)
          OpRType:                      w_next = StRExec;
          OpLw, OpSw:                   w_next = StMemAddr;
          OpAddi, OpAndi, OpOri, OpLui: w_next = StIExec;
          OpBeq, OpBne:                 w_next = StBranch;
          OpJ:                          w_next = StJump;
          default:                      w_next = StIllegal;
        endcase
      end
      StMemAddr:  w_next = (Opcode == OpSw) ? StMemWrite : StMemRead;
      StMemRead:  w_next = w_mem_ok ? StMemWb : StMemRead;
      StMemWrite: w_next = w_mem_ok ? StFetch : StMemWrite;
      StRExec:    w_next = StRWb;
      StIExec:    w_next = StIWb;
      default:    w_next = StFetch;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    BranchEQ  = 1'b0;
    BranchNE  = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSource  = 2'b00;
    ALUOp     = AluAdd;
    IllegalOp = 1'b0;
    unique case (r_state)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = w_mem_ok;
        PCWrite = w_mem_ok;
        ALUSrcB = 2'b01;
      end
      StDecode:   ALUSrcB = 2'b11;
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRead: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWrite: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StRExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = AluR;
      end
      StRWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      // Opcode comes from IR, which only loads in FETCH, so it is stable here.
      StIExec: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = imm_alu_op(Opcode);
      end
      StIWb:      RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA  = 1'b1;
        ALUOp    = AluSub;
        PCSource = 2'b01;
        BranchEQ = (Opcode == OpBeq);
        BranchNE = (Opcode == OpBne);
      end
      StJump: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      StIllegal:  IllegalOp = 1'b1;
      default: ;
    endcase
  end

  assign State = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized
// instruction streams against a per-instruction-step reference table.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'b0;
  logic       MemReady = 1'b1;
  logic       IRWrite, PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;
  logic [18:0] w_act;

  int total = 0;
  int bad = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  assign w_act = {IRWrite, PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp};

  // Instruction classes: 0 R, 1 lw, 2 sw, 3 imm, 4 branch, 5 jump, 6 illegal.
  function automatic int op_class(logic [5:0] op);
    case (op)
      6'b000000:                                  return 0;
      6'b100011:                                  return 1;
      6'b101011:                                  return 2;
      6'b001000, 6'b001100, 6'b001101, 6'b001111: return 3;
      6'b000100, 6'b000101:                       return 4;
      6'b000010:                                  return 5;
      default:                                    return 6;
    endcase
  endfunction

  function automatic int instr_len(int cls);
    case (cls)
      1:       return 5;
      0, 2, 3: return 4;
      default: return 3;
    endcase
  endfunction

  // Expected state and outputs for cycle 'step' of an instruction, from the control table.
  function automatic void model(input int step, input logic [5:0] op,
                                output logic [3:0] st, output logic [18:0] o);
    logic irw, pcw, beq, bne, iord, mr, mw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    int cls;
    cls = op_class(op);
    {irw, pcw, beq, bne, iord, mr, mw, m2r, rd, rw, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b100;
    st = StFetch;
    if (step == 0) begin
      mr = 1; irw = 1; pcw = 1; asb = 2'b01;
    end else if (step == 1) begin
      st = StDecode; asb = 2'b11;
    end else begin
      case (cls)
        0: if (step == 2) begin st = StRExec; asa = 1; aop = 3'b111; end
           else begin st = StRWb; rd = 1; rw = 1; end
        1: if (step == 2) begin st = StMemAddr; asa = 1; asb = 2'b10; end
           else if (step == 3) begin st = StMemRead; mr = 1; iord = 1; end
           else begin st = StMemWb; rw = 1; m2r = 1; end
        2: if (step == 2) begin st = StMemAddr; asa = 1; asb = 2'b10; end
           else begin st = StMemWrite; mw = 1; iord = 1; end
        3: if (step == 2) begin
             st = StIExec; asa = 1; asb = 2'b10;
             aop = (op == 6'b001100) ? 3'b110 : (op == 6'b001101) ? 3'b101 :
                   (op == 6'b001111) ? 3'b000 : 3'b100;
           end else begin st = StIWb; rw = 1; end
        4: begin
             st = StBranch; asa = 1; aop = 3'b001; pcs = 2'b01;
             beq = (op == 6'b000100); bne = (op == 6'b000101);
           end
        5: begin st = StJump; pcs = 2'b10; pcw = 1; end
        default: begin st = StIllegal; ill = 1; end
      endcase
    end
    o = {irw, pcw, beq, bne, iord, mr, mw, m2r, rd, rw, asa, asb, pcs, aop, ill};
  endfunction

  task automatic test_reset();
    logic [3:0] st;
    logic [18:0] o;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    model(0, 6'b0, st, o);
    total++;
    if (State !== st) begin bad++; $display("FAIL reset_state got %0d want %0d", State, st); end
    total++;
    if (w_act !== o) begin bad++; $display("FAIL reset_outs got %b want %b", w_act, o); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [3:0] exp_st [4] = '{StFetch, StDecode, StRExec, StRWb};
    Opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (State !== exp_st[i]) begin
        bad++; $display("FAIL add_state[%0d] got %0d want %0d", i, State, exp_st[i]);
      end
      total++;
      if (RegWrite !== (i == 3)) begin
        bad++; $display("FAIL add_regwrite[%0d] got %b want %b", i, RegWrite, (i == 3));
      end
      if (i == 2) begin
        total++;
        if (ALUOp !== 3'b111) begin bad++; $display("FAIL add_aluop got %b want 111", ALUOp); end
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (State !== StFetch) begin bad++; $display("FAIL add_end got %0d want %0d", State, StFetch); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [5] = '{StFetch, StDecode, StMemAddr, StMemRead, StMemWb};
    Opcode = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (State !== exp_st[i]) begin
        bad++; $display("FAIL lw_state[%0d] got %0d want %0d", i, State, exp_st[i]);
      end
      if (i == 3) begin
        total++;
        if ({MemRead, IorD} !== 2'b11) begin
          bad++; $display("FAIL lw_memread got %b want 11", {MemRead, IorD});
        end
      end
      if (i == 4) begin
        total++;
        if ({MemtoReg, RegWrite} !== 2'b11) begin
          bad++; $display("FAIL lw_wb got %b want 11", {MemtoReg, RegWrite});
        end
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (State !== StFetch) begin bad++; $display("FAIL lw_end got %0d want %0d", State, StFetch); end
  endtask

  task automatic test_ori_beq();
    Opcode = 6'b001101;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({State, ALUOp, ALUSrcB} !== {StIExec, 3'b101, 2'b10}) begin
      bad++; $display("FAIL ori_exec got %b want %b", {State, ALUOp, ALUSrcB}, {StIExec, 5'b10110});
    end
    repeat (2) @(negedge clk);
    Opcode = 6'b000100;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({State, BranchEQ, BranchNE, ALUOp, PCSource} !== {StBranch, 2'b10, 3'b001, 2'b01}) begin
      bad++; $display("FAIL beq_branch got %b want %b",
                      {State, BranchEQ, BranchNE, ALUOp, PCSource}, {StBranch, 7'b1000101});
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    Opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (IllegalOp !== (i == 2)) begin
        bad++; $display("FAIL ill_pulse[%0d] got %b want %b", i, IllegalOp, (i == 2));
      end
      if (i > 0) begin
        total++;
        if ({RegWrite, MemWrite, PCWrite} !== 3'b000) begin
          bad++; $display("FAIL ill_writes[%0d] got %b want 000", i, {RegWrite, MemWrite, PCWrite});
        end
      end
      @(negedge clk);
    end
    #1;
    total++;
    if ({State, IllegalOp} !== {StFetch, 1'b0}) begin
      bad++; $display("FAIL ill_end got %b want %b", {State, IllegalOp}, {StFetch, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [5:0] legal [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100,
                               6'b001101, 6'b001111, 6'b000100, 6'b000101, 6'b000010};
    logic [3:0] st;
    logic [18:0] o;
    logic [5:0] op;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 9)];
      Opcode = op;
      for (int s = 0; s < instr_len(op_class(op)); s++) begin
        #1;
        model(s, op, st, o);
        total++;
        if (State !== st) begin
          bad++; $display("FAIL rand_state n=%0d s=%0d op=%b got %0d want %0d", n, s, op, State, st);
        end
        total++;
        if (w_act !== o) begin
          bad++; $display("FAIL rand_outs n=%0d s=%0d op=%b got %b want %b", n, s, op, w_act, o);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    Opcode = 6'b100011;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (State !== StMemRead) begin
      bad++; $display("FAIL rst_pre got %0d want %0d", State, StMemRead);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({State, RegWrite, MemRead, IorD} !== {StFetch, 3'b010}) begin
      bad++; $display("FAIL rst_async got %b want %b", {State, RegWrite, MemRead, IorD},
                      {StFetch, 3'b010});
    end
    @(negedge clk);
    total++;
    if ({State, RegWrite} !== {StFetch, 1'b0}) begin
      bad++; $display("FAIL rst_held got %b want %b", {State, RegWrite}, {StFetch, 1'b0});
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({State, RegWrite} !== {StDecode, 1'b0}) begin
      bad++; $display("FAIL rst_first_edge got %b want %b", {State, RegWrite}, {StDecode, 1'b0});
    end
    reset = 1'b1;
    #1 reset = 1'b0;
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    Opcode = 6'b101011;
    MemReady = 1'b0;
    #1;
    total++;
    if ({IRWrite, PCWrite} !== 2'b00) begin
      bad++; $display("FAIL wait_fetch_hold got %b want 00", {IRWrite, PCWrite});
    end
    @(negedge clk);
    MemReady = 1'b1;
    #1;
    total++;
    if ({State, IRWrite, PCWrite} !== {StFetch, 2'b11}) begin
      bad++; $display("FAIL wait_fetch_go got %b want %b", {State, IRWrite, PCWrite}, {StFetch, 2'b11});
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      MemReady = (i == 3);
      #1;
      total++;
      if ({State, MemWrite} !== {StMemWrite, 1'b1}) begin
        bad++; $display("FAIL wait_sw[%0d] got %b want %b", i, {State, MemWrite}, {StMemWrite, 1'b1});
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (State !== StFetch) begin bad++; $display("FAIL wait_end got %0d want %0d", State, StFetch); end
  endtask
`else
  task automatic test_mem_wait();
    logic [3:0] exp_st [4] = '{StFetch, StDecode, StMemAddr, StMemWrite};
    Opcode = 6'b101011;
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (State !== exp_st[i]) begin
        bad++; $display("FAIL nowait_sw[%0d] got %0d want %0d", i, State, exp_st[i]);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (State !== StFetch) begin bad++; $display("FAIL nowait_end got %0d want %0d", State, StFetch); end
    MemReady = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_ori_beq();
    test_illegal();
    test_random();
    test_reset_mid_read();
    test_mem_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
